// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection controller.
package traffic_pkg;

    localparam int T_W = 5;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_A_GRN = 4'd1,
        S_A_YEL = 4'd2,
        S_AR1   = 4'd3,
        S_B_GRN = 4'd4,
        S_B_YEL = 4'd5,
        S_AR2   = 4'd6,
        S_PED   = 4'd7,
        S_FLASH = 4'd8
    } state_t;

    localparam logic [2:0] L_OFF = 3'b000;
    localparam logic [2:0] L_GRN = 3'b001;
    localparam logic [2:0] L_YEL = 3'b010;
    localparam logic [2:0] L_RED = 3'b100;

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter for phase durations; it stops at 1 so an expired phase can be held.
module phase_timer
    import traffic_pkg::*;
#(
    parameter logic [T_W-1:0] RST_VAL = T_W'(2)
) (
    input  logic           sys_clk,
    input  logic           sys_rst_p,
    input  logic           tick,
    input  logic           load,
    input  logic [T_W-1:0] load_val,
    output logic [T_W-1:0] cnt,
    output logic           expire
);

    // Load has priority over counting; a count of 0 or 1 never decrements.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_p) begin
            cnt <= RST_VAL;
        end else if (load) begin
            cnt <= load_val;
        end else if (tick && (cnt > T_W'(1))) begin
            cnt <= cnt - T_W'(1);
        end
    end

    // Terminal-count: the tick that lands on a count of 1 ends the phase.
    assign expire = tick && (cnt == T_W'(1));

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection sequencer with pedestrian phase and flash fallback.
//
//  state   | meaning
//  --------+---------------------------------------------------
//  IDLE    | all red after reset or flash, settles for AR_T
//  A_GRN   | main road green, held past minimum until a request
//  A_YEL   | main road yellow
//  AR1     | all-red clearance before side road or pedestrians
//  B_GRN   | side road green
//  B_YEL   | side road yellow
//  AR2     | all-red clearance before pedestrians or main road
//  PED     | walk phase, both roads red
//  FLASH   | en low: both roads blink yellow, timer parked at 0
module intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int G_A_T = 10,
    parameter int G_B_T = 6,
    parameter int Y_T   = 3,
    parameter int AR_T  = 2,
    parameter int PED_T = 5
) (
    input  logic           sys_clk,
    input  logic           sys_rst_p,
    input  logic           tick_1s,
    input  logic           en,
    input  logic           car_b,
    input  logic           ped_req,
    output logic [2:0]     light_a,
    output logic [2:0]     light_b,
    output logic           walk,
    output logic [T_W-1:0] light_t
);

    if (G_A_T < 1 || G_A_T > 31 || G_B_T < 1 || G_B_T > 31 || Y_T < 1 || Y_T > 31 ||
        AR_T < 1 || AR_T > 31 || PED_T < 1 || PED_T > 31) begin : g_param_err
        $error("intersection_ctrl: timing parameters must lie in 1..31");
    end

    state_t         state, state_nxt;
    logic           b_pend, ped_pend;
    logic           flash_ph, flash_nxt;
    logic           load, expire;
    logic [T_W-1:0] load_val;
    logic [2:0]     lamp_a_nxt, lamp_b_nxt;

    phase_timer #(.RST_VAL(T_W'(AR_T))) u_timer (
        .sys_clk   (sys_clk),
        .sys_rst_p (sys_rst_p),
        .tick      (tick_1s),
        .load      (load),
        .load_val  (load_val),
        .cnt       (light_t),
        .expire    (expire)
    );

    // Next-state selection; en low wins over any expiry in the same cycle.
    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = S_FLASH;
        end else if (state == S_FLASH) begin
            state_nxt = S_IDLE;
        end else if (expire) begin
            case (state)
                S_IDLE:  state_nxt = S_A_GRN;
                S_A_GRN: state_nxt = (b_pend || ped_pend) ? S_A_YEL : S_A_GRN;
                S_A_YEL: state_nxt = S_AR1;
                S_AR1:   state_nxt = b_pend ? S_B_GRN : S_PED;
                S_B_GRN: state_nxt = S_B_YEL;
                S_B_YEL: state_nxt = S_AR2;
                S_AR2:   state_nxt = ped_pend ? S_PED : S_A_GRN;
                S_PED:   state_nxt = S_A_GRN;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Timer reloads on every state change; FLASH parks the count at 0.
    always_comb begin
        load = (state_nxt != state);
        case (state_nxt)
            S_IDLE:          load_val = T_W'(AR_T);
            S_A_GRN:         load_val = T_W'(G_A_T);
            S_A_YEL, S_B_YEL: load_val = T_W'(Y_T);
            S_AR1, S_AR2:    load_val = T_W'(AR_T);
            S_B_GRN:         load_val = T_W'(G_B_T);
            S_PED:           load_val = T_W'(PED_T);
            default:         load_val = '0;
        endcase
    end

    // Flash phase restarts at "yellow on" on entry and toggles per tick.
    always_comb begin
        flash_nxt = 1'b0;
        if (state_nxt == S_FLASH && state == S_FLASH) begin
            flash_nxt = tick_1s ? ~flash_ph : flash_ph;
        end
    end

    // Lamp decode from the next state so the lamp registers track the state register.
    always_comb begin
        lamp_a_nxt = L_RED;
        lamp_b_nxt = L_RED;
        case (state_nxt)
            S_A_GRN: lamp_a_nxt = L_GRN;
            S_A_YEL: lamp_a_nxt = L_YEL;
            S_B_GRN: lamp_b_nxt = L_GRN;
            S_B_YEL: lamp_b_nxt = L_YEL;
            S_FLASH: begin
                lamp_a_nxt = flash_nxt ? L_OFF : L_YEL;
                lamp_b_nxt = flash_nxt ? L_OFF : L_YEL;
            end
            default: ;
        endcase
    end

    // State, flash phase and registered lamp outputs.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_p) begin
            state    <= S_IDLE;
            flash_ph <= 1'b0;
            light_a  <= L_RED;
            light_b  <= L_RED;
            walk     <= 1'b0;
        end else begin
            state    <= state_nxt;
            flash_ph <= flash_nxt;
            light_a  <= lamp_a_nxt;
            light_b  <= lamp_b_nxt;
            walk     <= (state_nxt == S_PED);
        end
    end

    // Request latches: clearing on phase entry beats a coincident request; frozen in flash.
    always_ff @(posedge sys_clk) begin
        if (sys_rst_p) begin
            b_pend   <= 1'b0;
            ped_pend <= 1'b0;
        end else begin
            if (state_nxt == S_B_GRN && state != S_B_GRN) begin
                b_pend <= 1'b0;
            end else if (car_b && en && state != S_FLASH) begin
                b_pend <= 1'b1;
            end
            if (state_nxt == S_PED && state != S_PED) begin
                ped_pend <= 1'b0;
            end else if (ped_req && en && state != S_FLASH) begin
                ped_pend <= 1'b1;
            end
        end
    end

endmodule

// File: doc/intersection_ctrl.md
INTERSECTION_CTRL -- requirements
Module: intersection_ctrl

Interface
REQ-001 SHALL have parameter G_A_T, default 10, main-road (A) minimum green in ticks.
REQ-002 SHALL have parameter G_B_T, default 6, side-road (B) green in ticks.
REQ-003 SHALL have parameter Y_T, default 3, yellow duration in ticks for either road.
REQ-004 SHALL have parameter AR_T, default 2, all-red clearance in ticks.
REQ-005 SHALL have parameter PED_T, default 5, pedestrian walk duration in ticks.
REQ-006 SHALL have port sys_clk, input, 1, sole clock.
REQ-007 SHALL have port sys_rst_p, input, 1, reset, synchronous, active-high.
REQ-008 SHALL have port tick_1s, input, 1, single-cycle 1 s enable pulse synchronous to sys_clk.
REQ-009 SHALL have port en, input, 1, 1 = normal sequencing, 0 = flash mode.
REQ-010 SHALL have port car_b, input, 1, side-road vehicle detector, level.
REQ-011 SHALL have port ped_req, input, 1, pedestrian button, pulse or level.
REQ-012 SHALL have port light_a, output, 3, road A lamp, one-hot {R,Y,G}: 001 green, 010 yellow, 100 red, 000 off.
REQ-013 SHALL have port light_b, output, 3, road B lamp, same encoding.
REQ-014 SHALL have port walk, output, 1, pedestrian walk lamp.
REQ-015 SHALL have port light_t, output, 5, remaining ticks of the current phase.

Function
REQ-016 SHALL implement states IDLE, A_GRN, A_YEL, AR1, B_GRN, B_YEL, AR2, PED, FLASH.
REQ-017 Lamp map SHALL be: IDLE/AR1/AR2/PED both red; A_GRN A=001 B=100; A_YEL A=010 B=100; B_GRN A=100 B=001; B_YEL A=100 B=010; walk=1 only in PED.
REQ-018 On entry to any timed state, light_t SHALL load that state's duration: IDLE=AR_T, A_GRN=G_A_T, A_YEL/B_YEL=Y_T, AR1/AR2=AR_T, B_GRN=G_B_T, PED=PED_T.
REQ-019 On tick_1s with light_t>1, light_t SHALL decrement by 1; with light_t==1, the state SHALL advance on that same cycle and light_t SHALL reload.
REQ-020 Transitions on expiry: IDLE->A_GRN; A_YEL->AR1; AR1->B_GRN if b_pend, else PED; B_GRN->B_YEL; B_YEL->AR2; AR2->PED if ped_pend, else A_GRN; PED->A_GRN.
REQ-021 A_GRN on expiry SHALL move to A_YEL only if b_pend or ped_pend; otherwise it SHALL hold light_t at 1 and leave A_GRN on the first tick_1s at which a request is pending.
REQ-022 b_pend SHALL be set by car_b=1 and cleared on entry to B_GRN; ped_pend SHALL be set by ped_req=1 and cleared on entry to PED.
REQ-023 A request asserted in the same cycle as its clearing entry SHALL be absorbed, leaving the flag cleared.
REQ-024 Requests arriving during B_GRN or PED SHALL latch and be served in the next cycle.
REQ-025 en=0 SHALL force FLASH on the next sys_clk from any state; in FLASH, light_a and light_b SHALL toggle together between 010 and 000 on each tick_1s, starting at 010; walk=0; light_t=0; pending flags SHALL be held.
REQ-026 en returning to 1 in FLASH SHALL enter IDLE on the next sys_clk (all-red, light_t=AR_T).
REQ-027 en=0 SHALL take priority over a coincident tick expiry.
REQ-028 Parameters SHALL be in the range 1..31; a parameter value of 0 SHALL be an elaboration error.
REQ-029 Outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-030 While sys_rst_p=1 at a sys_clk edge, the block SHALL set state=IDLE, light_a=light_b=100, walk=0, light_t=AR_T, b_pend=ped_pend=0 and the flash phase bit to 0.
REQ-031 Reset SHALL override en and tick_1s, and asserting it mid-phase SHALL abandon the phase without completing any yellow.

Structure
REQ-032 Package traffic_pkg SHALL hold the state enum, lamp encodings (L_OFF, L_GRN, L_YEL, L_RED) and the timer width constant (5).
REQ-033 Sub-module phase_timer SHALL implement a loadable 5-bit down-counter with tick enable and an expire flag; the FSM, request latches and lamp decode SHALL live in intersection_ctrl.

Verification
REQ-034 Reset, en=1, no requests -> light_t counts 2 then 1 in IDLE, then A_GRN with light_t=10 counting to 1 and held at 1 indefinitely with A=001.
REQ-035 car_b pulse at A_GRN tick 4 -> A_GRN for 10 ticks, A_YEL 3, AR1 2, B_GRN 6, B_YEL 3, AR2 2, A_GRN; b_pend=0 after B_GRN entry.
REQ-036 ped_req only -> after AR1 goes directly to PED, walk=1 for 5 ticks, then A_GRN; car_b and ped_req both pending -> B phase, AR2, PED, A_GRN.
REQ-037 car_b asserted in the exact cycle B_GRN is entered, then deasserted -> no second B phase in the following cycle.
REQ-038 en=0 during B_GRN at light_t=4 -> FLASH on the next clock, lamps 010/000/010 on successive ticks; en=1 -> IDLE with light_t=2.
REQ-039 sys_rst_p pulse during A_YEL at light_t=2 -> next cycle state IDLE, both lamps 100, light_t=2, pending flags cleared.
